dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Sits directly downstream of the single-cycle datapath, between its aluout/writedata/readdata ports and a word-wide external data memory with a req/ack handshake.
- Performs word, halfword and byte loads and stores. Sub-word stores are done as read-modify-write.
- Lane-aligns load data so the datapath's byte/half extension logic always sees the selected lane in bits [7:0]/[15:0].
- Stalls the core (freezes PC and register writes) until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: handshake wait limit in cycles; used only when DMEM_TIMEOUT_EN is defined.
- TW, $clog2(TIMEOUT_CYCLES+1): timeout counter width; derived, do not override.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- memread  in  1  load request from control
- memwrite  in  1  store request from control
- size  in  2  00 word, 01 half, 10 byte, 11 treated as word
- addr  in  32  byte address (datapath aluout)
- wdata  in  32  store data (datapath writedata)
- rdata  out  32  lane-aligned load data (to datapath readdata)
- stall  out  1  core must hold state while high
- misaligned  out  1  misaligned access flag
- bus_err  out  1  timeout abort flag
- mem_req  out  1  external transfer request
- mem_we  out  1  1 = write transfer
- mem_addr  out  32  word address, bits [1:0] always 00
- mem_wdata  out  32  external write data
- mem_rdata  in  32  external read data
- mem_ack  in  1  transfer completes on any rising edge with mem_req & mem_ack

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE; mem_req=0, mem_we=0, stall=0, misaligned=0, bus_err=0, rdata=0; all capture registers 0.
- Byte order is little-endian: lane k = bits [8k+7:8k].
- States: IDLE, RD, WR, DONE.
- IDLE:
  - An access is memread|memwrite. If both are high, it is a write.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=00. A misaligned access produces misaligned=1 for that cycle only, stall=0, rdata=0, no external transfer, and the state stays IDLE.
  - An aligned access gives stall=1 combinationally in that cycle. On the clock edge, addr, wdata, size and direction are captured.
  - Next state: a load or sub-word store goes to RD; a word store goes to WR.
- RD:
  - mem_req=1, mem_we=0; stall=1.
  - On ack, mem_rdata is captured.
  - A load goes to DONE. A sub-word store merges and goes to WR.
  - Byte merge: captured lane addr[1:0] is replaced with wdata[7:0].
  - Half merge: lanes {2a+1,2a} are replaced with wdata[15:0], where a=addr[1].
- WR:
  - mem_req=1, mem_we=1; mem_wdata is the merged word (or wdata for a word store); stall=1.
  - On ack, go to DONE.
- DONE:
  - stall=0 for exactly one cycle; the core completes the instruction on this edge.
  - For a load, rdata is the captured word shifted right by 8*addr[1:0] (byte) or 16*addr[1] (half); word loads are unshifted. Upper bits are zero-filled.
  - For a store, rdata=0.
  - Next state is always IDLE. DONE never starts a new access.
- Outside DONE and the misaligned pulse, rdata holds its last value.
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req is high.
- mem_req stays high across an RD->WR transition. The slave gives one ack per transfer.
- Minimum latency (ack in the first cycle of each transfer): load 3 cycles, word store 3, sub-word store 4.
- Inputs are sampled only in IDLE. The core holds them stable while stall is high.
- Reset mid-transfer: mem_req drops immediately, state goes to IDLE, and the partial RMW is discarded (memory is unchanged if WR was not acked).

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A TW-bit counter clears on entry to RD/WR and increments each cycle mem_req is high without ack.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: mem_req drops next cycle and the state goes to DONE.
  - In that DONE cycle, bus_err=1 and rdata=0; no write is performed.
- Not defined: no counter, bus_err is constant 0, and RD/WR wait indefinitely.

Test Plan:
- Word load: addr=0x10, memory word 0xAABBCCDD, ack after 2 wait cycles -> stall high 4 cycles, mem_addr=0x10, rdata=0xAABBCCDD in DONE.
- Byte load: addr=0x13, same word -> rdata=0x000000AA. Half load at addr=0x12 -> rdata=0x0000AABB.
- Byte store: addr=0x21, wdata=0x11223344, memory 0xAABBCCDD -> RD then WR with mem_wdata=0xAABB44DD, mem_req continuous across the transition, 4 cycles minimum.
- Misaligned: word access at addr=0x06 and half at addr=0x05 -> misaligned=1 for one cycle, stall=0, mem_req never high, rdata=0.
- Reset asserted during WR of an RMW -> mem_req=0 asynchronously, state IDLE, memory unchanged. The next load completes normally.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> abort after 4 wait cycles, bus_err=1 and rdata=0 in DONE, then IDLE.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: word/half/byte loads and RMW stores over req/ack.
// Define DMEM_TIMEOUT_EN to abort stuck transfers after TIMEOUT_CYCLES.
module dmem_access_unit #(
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] word_q, word_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        access, in_sub, in_mis, err_now;

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [1:0]  sz,
                                         input logic [1:0]  a);
      logic [31:0] m, d;
      if (sz == 2'b10) begin
         m = 32'h0000_00FF << {a, 3'b000};
         d = wd << {a, 3'b000};
      end else begin
         m = 32'h0000_FFFF << {a[1], 4'b0000};
         d = wd << {a[1], 4'b0000};
      end
      return (old & ~m) | (d & m);
   endfunction

   function automatic logic [31:0] align(input logic [31:0] w,
                                         input logic [1:0]  sz,
                                         input logic [1:0]  a);
      unique case (sz)
         2'b10:   return (w >> {a, 3'b000}) & 32'h0000_00FF;
         2'b01:   return (w >> {a[1], 4'b0000}) & 32'h0000_FFFF;
         default: return w;
      endcase
   endfunction

   assign access = memread | memwrite;
   assign in_sub = (size == 2'b01) | (size == 2'b10);
   assign in_mis = (size == 2'b01) ? addr[0] : (!in_sub && addr[1:0] != 2'b00);

   assign mem_req   = (state_q == S_RD) | (state_q == S_WR);
   assign mem_we    = (state_q == S_WR);
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = word_q;
   assign rdata     = rdata_d;

`ifdef DMEM_TIMEOUT_EN
   logic [TW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   assign err_now = (state_q == S_DONE) & err_q;
`else
   assign err_now = 1'b0;
`endif
   assign bus_err = err_now;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      size_d     = size_q;
      we_d       = we_q;
      rdata_d    = rdata_q;
      stall      = 1'b0;
      misaligned = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (access && in_mis) begin
               misaligned = 1'b1;
               rdata_d    = 32'h0;
            end else if (access) begin
               stall   = 1'b1;
               addr_d  = addr;
               word_d  = wdata;
               size_d  = size;
               we_d    = memwrite;
               state_d = (memwrite && !in_sub) ? S_WR : S_RD;
            end
         end
         S_RD: begin
            stall = 1'b1;
            if (mem_ack) begin
               // word_q still holds the store data until the read returns
               word_d  = we_q ? merge(mem_rdata, word_q, size_q, addr_q[1:0])
                              : mem_rdata;
               state_d = we_q ? S_WR : S_DONE;
            end
         end
         S_WR: begin
            stall = 1'b1;
            if (mem_ack) state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
            rdata_d = (we_q || err_now) ? 32'h0
                                        : align(word_q, size_q, addr_q[1:0]);
         end
      endcase
`ifdef DMEM_TIMEOUT_EN
      cnt_d = '0;
      err_d = 1'b0;
      if (mem_req && !mem_ack) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == TW'(TIMEOUT_CYCLES)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= 32'h0;
         word_q  <= 32'h0;
         rdata_q <= 32'h0;
         size_q  <= 2'b00;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         we_q    <= we_d;
      end
   end

`ifdef DMEM_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: random slave latency, byte-array memory model,
// directed cases plus randomized loads/stores.
module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        memread, memwrite;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        stall, misaligned, bus_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;

   dmem_access_unit dut (
      .clk(clk), .reset(reset),
      .memread(memread), .memwrite(memwrite), .size(size),
      .addr(addr), .wdata(wdata), .rdata(rdata),
      .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] mem [0:15];

   int fixed_wait = -1;
   int max_wait = 3;
   bit hold_wr = 0;
   int wait_cnt = 0;
   bit waiting = 0;
   int waits_total = 0;

   bit          cur_active = 0;
   bit          cur_rd_ok = 0;
   logic [31:0] cur_waddr, cur_wexp;
   bit          prev_req = 0;
   int          last_cycles;
   logic [31:0] last_rdata;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // slave: one ack per transfer after a drawn number of wait cycles
   always @(negedge clk) begin
      if (!mem_req) begin
         mem_ack = 1'b0;
         waiting = 0;
         mem_rdata = $urandom;
      end else begin
         if (!waiting || mem_ack) begin
            waiting = 1;
            wait_cnt = (fixed_wait >= 0) ? fixed_wait
                                         : int'($urandom_range(max_wait, 0));
            waits_total += wait_cnt;
         end
         if (hold_wr && mem_we) begin
            mem_ack = 1'b0;
         end else if (wait_cnt == 0) begin
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr[5:2]];
            if (mem_we) mem[mem_addr[5:2]] = mem_wdata;
         end else begin
            mem_ack = 1'b0;
            wait_cnt--;
            mem_rdata = $urandom;
         end
      end
   end

   // bus-side checks every cycle of an active transaction
   always @(negedge clk) begin
      #2;
      if (cur_active) begin
         if (mem_req) begin
            chk("mem_addr", mem_addr, cur_waddr);
            if (mem_we) chk("mem_wdata", mem_wdata, cur_wexp);
            else chk("read_phase_allowed", {31'b0, cur_rd_ok}, 32'd1);
         end
         if (prev_req && !mem_req) chk("req_drop_in_done", {31'b0, stall}, 32'd0);
      end
      prev_req = mem_req;
   end

   task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
      bit half, byt, mis, sub;
      int idx, minc, n;
      logic [7:0] b [4];
      logic [31:0] old, exp_mem, exp_rd;
      half = (sz == 2'b01);
      byt  = (sz == 2'b10);
      sub  = half || byt;
      mis  = half ? a[0] : (!byt && a[1:0] != 2'b00);
      idx  = int'(a[5:2]);
      old  = mem[idx];
      for (int k = 0; k < 4; k++) b[k] = old[8*k +: 8];
      exp_rd = 32'h0;
      minc = 3;
      if (wr) begin
         if (byt) begin
            b[a[1:0]] = wd[7:0];
         end else if (half) begin
            b[{a[1], 1'b0}] = wd[7:0];
            b[{a[1], 1'b1}] = wd[15:8];
         end else begin
            for (int k = 0; k < 4; k++) b[k] = wd[8*k +: 8];
         end
         if (sub) minc = 4;
      end else if (byt) begin
         exp_rd = {24'h0, b[a[1:0]]};
      end else if (half) begin
         exp_rd = {16'h0, b[{a[1], 1'b1}], b[{a[1], 1'b0}]};
      end else begin
         exp_rd = old;
      end
      exp_mem = {b[3], b[2], b[1], b[0]};
      if (mis) exp_mem = old;

      @(negedge clk);
      memread = rd; memwrite = wr; size = sz; addr = a; wdata = wd;
      cur_waddr = {a[31:2], 2'b00};
      cur_wexp = exp_mem;
      cur_rd_ok = !wr || sub;
      waits_total = 0;
      cur_active = !mis;
      #1;
      if (mis) begin
         chk("mis_flag", {31'b0, misaligned}, 32'd1);
         chk("mis_stall", {31'b0, stall}, 32'd0);
         chk("mis_rdata", rdata, 32'h0);
         chk("mis_req", {31'b0, mem_req}, 32'd0);
         @(negedge clk);
         memread = 0; memwrite = 0;
         #1;
         chk("mis_one_cycle", {31'b0, misaligned}, 32'd0);
         chk("mis_rdata_hold", rdata, 32'h0);
         chk("mis_no_req", {31'b0, mem_req}, 32'd0);
         chk("mis_mem", mem[idx], old);
         last_rdata = rdata;
         return;
      end
      chk("stall_first", {31'b0, stall}, 32'd1);
      n = 1;
      while (stall && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      last_cycles = n;
      last_rdata = rdata;
      if (stall) begin
         chk("done_reached", {31'b0, stall}, 32'd0);
      end else begin
         chk("done_rdata", rdata, exp_rd);
         chk("done_bus_err", {31'b0, bus_err}, 32'd0);
         chk("latency", n, minc + waits_total);
      end
      memread = 0; memwrite = 0;
      @(negedge clk);
      #1;
      cur_active = 0;
      chk("rdata_hold", rdata, exp_rd);
      chk("mem_after", mem[idx], exp_mem);
      chk("idle_stall", {31'b0, stall}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit rd, wr;
      logic [31:0] a;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      reset = 1; memread = 0; memwrite = 0; size = 0; addr = 0; wdata = 0;
      #1;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mis", {31'b0, misaligned}, 32'd0);
      chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 0;

      mem[4] = 32'hAABBCCDD;
      fixed_wait = 2;
      do_op(1, 0, 2'b00, 32'h10, 32'h0);
      chk("tp_word_stall_cycles", last_cycles - 1, 32'd4);
      chk("tp_word_rdata", last_rdata, 32'hAABBCCDD);
      fixed_wait = 0;
      do_op(1, 0, 2'b10, 32'h13, 32'h0);
      chk("tp_byte_rdata", last_rdata, 32'h000000AA);
      do_op(1, 0, 2'b01, 32'h12, 32'h0);
      chk("tp_half_rdata", last_rdata, 32'h0000AABB);
      chk("tp_half_latency", last_cycles, 32'd3);
      mem[8] = 32'hAABBCCDD;
      do_op(0, 1, 2'b10, 32'h21, 32'h11223344);
      chk("tp_bstore_mem", mem[8], 32'hAABB44DD);
      chk("tp_bstore_cycles", last_cycles, 32'd4);
      do_op(0, 1, 2'b00, 32'h24, 32'hCAFEF00D);
      chk("tp_wstore_mem", mem[9], 32'hCAFEF00D);
      chk("tp_wstore_cycles", last_cycles, 32'd3);
      do_op(1, 0, 2'b00, 32'h06, 32'h0);
      do_op(0, 1, 2'b01, 32'h05, 32'h1234);
      do_op(1, 1, 2'b11, 32'h0B, 32'h1234);

      // reset while the write half of an RMW is pending
      mem[12] = 32'h01020304;
      hold_wr = 1;
      @(negedge clk);
      memwrite = 1; size = 2'b10; addr = 32'h31; wdata = 32'hFF;
      n = 0;
      while (!(mem_req && mem_we) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_wr", {31'b0, mem_we}, 32'd1);
      @(negedge clk);
      #1;
      reset = 1;
      #1;
      chk("rst_async_req", {31'b0, mem_req}, 32'd0);
      chk("rst_async_we", {31'b0, mem_we}, 32'd0);
      memwrite = 0;
      @(negedge clk);
      reset = 0;
      hold_wr = 0;
      #1;
      chk("rst_mem_kept", mem[12], 32'h01020304);
      chk("rst_idle_stall", {31'b0, stall}, 32'd0);
      chk("rst_rdata_clr", rdata, 32'h0);
      do_op(1, 0, 2'b00, 32'h30, 32'h0);
      chk("rst_then_load", last_rdata, 32'h01020304);

      fixed_wait = -1;
      for (int i = 0; i < 150; i++) begin
         rd = 1'($urandom);
         wr = 1'($urandom);
         if (!rd && !wr) rd = 1;
         a = $urandom;
         if ($urandom_range(1, 0) == 0) a[1:0] = 2'b00;
         do_op(rd, wr, 2'($urandom), a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
